// File: rtl/btn_pulse_gen.sv
// btn_pulse_gen: button front end for the VGA controller FSMs (clk_16 domain).
//
// Four raw pushbuttons are each synchronised (two flops), debounced and
// edge-detected.  The resulting requests go through a pending register and a
// fixed-priority arbiter so that at most one one-cycle command pulse is
// produced per clock.  A request that loses arbitration waits in the pending
// register and is issued later, so presses are never lost.
//
// Optional feature (compile-time macro BTN_REPEAT_EN): auto-repeat for left
// and right.  A repeat request fires REPEAT_DELAY cycles after the debounced
// press, then every REPEAT_PERIOD cycles while the button stays held.  With
// the macro undefined every button yields exactly one pulse per press.
//
// Ports:
//   clk_16         in   sole clock
//   rst_n          in   asynchronous active-low reset
//   btn_en_raw     in   raw button levels, active high, asynchronous
//   btn_back_raw   in
//   btn_left_raw   in
//   btn_right_raw  in
//   en             out  one-cycle command pulses, at most one high per cycle
//   back           out
//   left           out
//   right          out
//   pressed        out  debounced levels {right, left, back, en}

module btn_pulse_gen #(
  parameter int unsigned DEBOUNCE_CYC  = 16,
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned REPEAT_DELAY  = 512,
  parameter int unsigned REPEAT_PERIOD = 128
) (
  input  logic       clk_16,
  input  logic       rst_n,
  input  logic       btn_en_raw,
  input  logic       btn_back_raw,
  input  logic       btn_left_raw,
  input  logic       btn_right_raw,
  output logic       en,
  output logic       back,
  output logic       left,
  output logic       right,
  output logic [3:0] pressed
);

  localparam int unsigned NumBtn = 4;
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYC - 1);

  // Channel order everywhere: bit 0 en, 1 back, 2 left, 3 right.
  logic [NumBtn-1:0] raw;
  assign raw = {btn_right_raw, btn_left_raw, btn_back_raw, btn_en_raw};

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser
  // ---------------------------------------------------------------------------
  logic [NumBtn-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk_16 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce: the level only flips after DEBOUNCE_CYC consecutive cycles of
  // disagreement; a single agreeing cycle restarts the count.
  // ---------------------------------------------------------------------------
  logic [NumBtn-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NumBtn-1:0]            lvl_q, lvl_d;

  always_comb begin
    cnt_d = cnt_q;
    lvl_d = lvl_q;
    for (int i = 0; i < NumBtn; i++) begin
      if (sync2_q[i] == lvl_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntLast) begin
        lvl_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_16 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      lvl_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      lvl_q <= lvl_d;
    end
  end

  assign pressed = lvl_q;

  // Rising edge taken from the next-state level so the pulse leaves in the
  // same edge the debounced level rises.
  logic [NumBtn-1:0] edge_req;
  assign edge_req = lvl_d & ~lvl_q;

  // ---------------------------------------------------------------------------
  // Request sources
  // ---------------------------------------------------------------------------
  logic [NumBtn-1:0] new_req;

`ifdef BTN_REPEAT_EN
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                  : REPEAT_PERIOD;
  localparam int unsigned RepW = $clog2(RepMax + 1);
  localparam logic [RepW-1:0] DelayLast  = RepW'(REPEAT_DELAY - 1);
  localparam logic [RepW-1:0] PeriodLast = RepW'(REPEAT_PERIOD - 1);

  // Index 0 serves left (channel 2), index 1 serves right (channel 3).
  logic [1:0][RepW-1:0] rep_cnt_q, rep_cnt_d;
  logic [1:0]           rep_first_q, rep_first_d;  // still waiting for first repeat
  logic [1:0]           rep_req;

  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
    rep_req     = '0;
    for (int i = 0; i < 2; i++) begin
      if (!lvl_q[i+2]) begin
        rep_cnt_d[i]   = '0;
        rep_first_d[i] = 1'b1;
      end else if (rep_cnt_q[i] == (rep_first_q[i] ? DelayLast : PeriodLast)) begin
        rep_cnt_d[i]   = '0;
        rep_first_d[i] = 1'b0;
        // A release already seen by the synchroniser suppresses the repeat,
        // so no extra pulse slips out while the release is being debounced.
        rep_req[i]     = sync2_q[i+2];
      end else begin
        rep_cnt_d[i] = rep_cnt_q[i] + RepW'(1);
      end
    end
  end

  always_ff @(posedge clk_16 or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 2'b11;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
    end
  end

  assign new_req = edge_req | {rep_req, 2'b00};
`else
  assign new_req = edge_req;
`endif

  // ---------------------------------------------------------------------------
  // Pending register and fixed-priority arbiter (en > back > left > right)
  // ---------------------------------------------------------------------------
  logic [NumBtn-1:0] pend_q, pend_d;
  logic [NumBtn-1:0] cand;
  logic [NumBtn-1:0] grant_q, grant_d;

  always_comb begin
    cand    = pend_q | new_req;
    grant_d = '0;
    if (cand[0]) begin
      grant_d = 4'b0001;
    end else if (cand[1]) begin
      grant_d = 4'b0010;
    end else if (cand[2]) begin
      grant_d = 4'b0100;
    end else if (cand[3]) begin
      grant_d = 4'b1000;
    end
    // A repeated request for an already pending channel merges into it.
    pend_d = cand & ~grant_d;
  end

  always_ff @(posedge clk_16 or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= '0;
      grant_q <= '0;
    end else begin
      pend_q  <= pend_d;
      grant_q <= grant_d;
    end
  end

  assign en    = grant_q[0];
  assign back  = grant_q[1];
  assign left  = grant_q[2];
  assign right = grant_q[3];

`ifndef SYNTHESIS
  localparam bit ParamsOk = (DEBOUNCE_CYC >= 2) && (DEBOUNCE_CYC <= 255) &&
                            ((CNT_W >= 32) || ((64'd1 << CNT_W) > 64'(DEBOUNCE_CYC))) &&
                            (REPEAT_DELAY >= 1) && (REPEAT_PERIOD >= 1);

  params_ok_a: assert property (@(posedge clk_16) ParamsOk)
    else $error("btn_pulse_gen: illegal parameter set");

  grant_onehot_a: assert property (@(posedge clk_16) disable iff (!rst_n)
                                   $onehot0(grant_q))
    else $error("btn_pulse_gen: more than one command pulse");
`endif

endmodule
